// File: rtl/sample_streamer_if.sv
// Sample stream from sample_streamer to the IIR filter input.
// The streamer drives data_en/data; data is zero whenever data_en is low.
interface sample_streamer_if #(
  parameter int DATA_W = 16
);
  logic                     data_en;
  logic signed [DATA_W-1:0] data;

  modport master (output data_en, output data);
  modport slave  (input  data_en, input  data);
endinterface

// File: rtl/sample_streamer.sv
// sample_streamer: host-filled sample FIFO replayed onto the filter input strobe with a
// programmable idle gap between samples.
// Optional feature macro: SEQ_LOOP_EN. When defined, loop=1 during an emit rewrites the popped
// sample to the tail so the pattern repeats until stop or rst. When undefined, loop is ignored.
module sample_streamer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int GAP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  input  logic [GAP_W-1:0]         gap,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic                     busy,
  output logic                     done,
  sample_streamer_if.master        strm
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StEmit, StGap} state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, host_slot;
  logic [CntW-1:0]          count_q, count_d;
  logic                     full_q;
  logic                     pop, push, recirc;
  logic [GAP_W-1:0]         gap_cnt_q;
  logic                     busy_q, done_q, data_en_q;
  logic signed [DATA_W-1:0] data_q, head;

`ifdef SEQ_LOOP_EN
  // The sample on the output (data_q) is the one being popped, so it is the one recirculated.
  assign recirc = (state_q == StEmit) && loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign recirc      = 1'b0;
`endif

  // FIFO next-state and the head value presented by the next emit.
  always_comb begin
    pop       = (state_q == StEmit);
    push      = wr_en && !full_q;
    // A recirculated sample takes the tail slot first; a host sample goes right behind it.
    host_slot = wr_ptr_q + PtrW'(recirc);
    wr_ptr_d  = host_slot + PtrW'(push);
    rd_ptr_d  = rd_ptr_q + PtrW'(pop);
    count_d   = count_q + CntW'(push) + CntW'(recirc) - CntW'(pop);
    // Back-to-back emit from a single stored sample: the next head is being written this edge.
    if (pop && count_q == CntW'(1)) begin
      head = recirc ? data_q : wr_data;
    end else begin
      head = mem_q[rd_ptr_d];
    end
  end

  // Sample storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (recirc) mem_q[wr_ptr_q] <= data_q;
    if (push)   mem_q[host_slot] <= wr_data;
  end

  // FIFO pointers, occupancy and full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CntW'(DEPTH));
    end
  end

  // Replay FSM with registered strobe, sample, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_en_q <= 1'b0;
      data_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      data_en_q <= 1'b0;
      data_q    <= '0;
      unique case (state_q)
        StIdle: begin
          if (start && count_q != '0) begin
            state_q   <= StEmit;
            busy_q    <= 1'b1;
            data_en_q <= 1'b1;
            data_q    <= head;
          end
        end
        StEmit: begin
          if (stop || count_d == '0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap == '0) begin
            data_en_q <= 1'b1;
            data_q    <= head;
          end else begin
            state_q   <= StGap;
            gap_cnt_q <= gap;
          end
        end
        StGap: begin
          if (stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_cnt_q == GAP_W'(1)) begin
            state_q   <= StEmit;
            data_en_q <= 1'b1;
            data_q    <= head;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign full         = full_q;
  assign level        = count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign strm.data_en = data_en_q;
  assign strm.data    = data_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Bench for sample_streamer: directed scenarios plus randomized fill/replay rounds, checked
// against a queue model of stored samples and the strobe schedule implied by the gap setting.
module tb_sample_streamer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int GAP_W  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     rst, wr_en, start, stop, loop;
  logic signed [DATA_W-1:0] wr_data;
  logic [GAP_W-1:0]         gap;
  logic                     full, busy, done;
  logic [LVL_W-1:0]         level;

  sample_streamer_if #(.DATA_W(DATA_W)) strm ();

  sample_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .level   (level),
    .gap     (gap),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .busy    (busy),
    .done    (done),
    .strm    (strm)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Samples the host has successfully stored and not yet seen replayed, oldest first.
  logic signed [DATA_W-1:0] model_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic write_one(input logic signed [DATA_W-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    if (model_q.size() < DEPTH) model_q.push_back(v);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic check_fifo(input string tag);
    @(negedge clk);
    check({tag, " level"}, 64'(level), 64'(model_q.size()));
    check({tag, " full"}, 64'(full), 64'(model_q.size() == DEPTH));
    @(posedge clk); #1;
  endtask

  // Start a replay and compare every cycle against the expected strobe schedule. stop_k >= 0
  // raises stop during the stop_k-th emit; with_stop raises stop with start; restart pulses
  // start again one cycle into the replay.
  task automatic replay(input int g, input int stop_k, input bit with_stop, input bit restart);
    int sz, n_emit, p, last, budget;
    sz     = model_q.size();
    n_emit = (stop_k >= 0 && stop_k + 1 < sz) ? stop_k + 1 : sz;
    p      = g + 1;
    last   = (n_emit == 0) ? -2 : (n_emit - 1) * p;
    budget = (n_emit == 0) ? 3 : last + 3;
    gap    = GAP_W'(g);
    start  = 1'b1;
    stop   = with_stop;
    for (int i = 0; i < budget; i++) begin
      logic [DATA_W+2:0] e;
      bit                strobe;
      @(posedge clk); #1;
      start = restart && (i == 1);
      stop  = (stop_k >= 0) && (i == stop_k * p);
      @(negedge clk);
      strobe = (i <= last) && (i % p == 0);
      e = {strobe, i <= last, i == last + 1, strobe ? model_q[i / p] : DATA_W'(0)};
      check("replay", 64'({strm.data_en, busy, done, strm.data}), 64'(e));
    end
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (n_emit) void'(model_q.pop_front());
    check_fifo("after replay");
  endtask

  initial begin
    int n, g, sk;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; gap = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;

    // Reset values.
    do_reset();
    @(negedge clk);
    check("reset outputs", 64'({strm.data_en, busy, done, strm.data}), 64'(0));
    @(posedge clk); #1;
    check_fifo("reset");

    // Start with an empty FIFO is ignored.
    replay(0, -1, 1'b0, 1'b0);

    // 1..4 back to back; a start during the replay is ignored.
    for (int i = 1; i <= 4; i++) write_one(DATA_W'(i));
    check_fifo("four written");
    replay(0, -1, 1'b0, 1'b1);

    // 1..3 with gap 2.
    for (int i = 1; i <= 3; i++) write_one(DATA_W'(i));
    replay(2, -1, 1'b0, 1'b0);

    // Overfill: the 9th sample is dropped.
    for (int i = 1; i <= 9; i++) write_one(DATA_W'(i * 3 - 20));
    check_fifo("overfill");
    replay(0, -1, 1'b0, 1'b0);

    // Stop on the 2nd emit leaves 3 queued; stop+start together restarts (start wins).
    for (int i = 0; i < 5; i++) write_one(DATA_W'(100 + i));
    replay(0, 1, 1'b0, 1'b0);
    replay(1, -1, 1'b1, 1'b0);

    // Reset after the 2nd strobe: strobe suppressed, FIFO empty, no done.
    for (int i = 1; i <= 4; i++) write_one(DATA_W'(i));
    gap = GAP_W'(1);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("rst seq strobe1", 64'({strm.data_en, busy, strm.data}), 64'({2'b11, 16'sd1}));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst seq gap", 64'({strm.data_en, busy, strm.data}), 64'({2'b01, 16'sd0}));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst seq strobe2", 64'({strm.data_en, busy, strm.data}), 64'({2'b11, 16'sd2}));
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    model_q.delete();
    @(negedge clk);
    check("rst seq outputs", 64'({strm.data_en, busy, done, strm.data}), 64'(0));
    check("rst seq level", 64'(level), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst seq no done", 64'({busy, done}), 64'(0));
    @(posedge clk); #1;

`ifdef SEQ_LOOP_EN
    // Loop -1,5 back to back, then stop; level holds at 2 and the pattern stays queued.
    write_one(-16'sd1);
    write_one(16'sd5);
    loop  = 1'b1;
    gap   = '0;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = (i == 5);
      @(negedge clk);
      check("loop strobe", 64'({strm.data_en, busy, done, strm.data}),
            64'({3'b110, (i % 2 == 1) ? 16'sd5 : -16'sd1}));
      check("loop level", 64'(level), 64'(2));
    end
    @(posedge clk); #1;
    stop = 1'b0;
    loop = 1'b0;
    @(negedge clk);
    check("loop done", 64'({strm.data_en, busy, done, strm.data}), 64'({3'b001, 16'sd0}));
    @(posedge clk); #1;
    check_fifo("loop end");
    replay(0, -1, 1'b0, 1'b0);
`endif

    // Randomized fill/replay rounds; leftovers from stopped replays carry over.
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(1, DEPTH + 1));
      for (int j = 0; j < n; j++) write_one(DATA_W'($urandom));
      check_fifo("random fill");
      g  = int'($urandom_range(0, 3));
      sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, model_q.size() - 1)) : -1;
      replay(g, sk, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
